accum_core: RTL and testbench
=============================

# accum_core

Parametrised multi-cycle accumulator processor core; successor to the fixed 12-bit/17-bit-bus processor top. Width, register count and address width are generic. Instruction and data memory are reached through valid/ready-style request/acknowledge handshakes that tolerate wait states. Adds asynchronous reset, zero/carry flags, conditional branches, illegal-opcode trapping and a sticky halt.

## Interface
- DATA_W, 12, accumulator/register/data-memory word width
- ADDR_W, 12, PC and data-address width; instruction word is 5+ADDR_W bits
- NREG, 4, general registers R0..R(NREG-1); power of two, ≥2
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- im_req / im_addr  out  1 / ADDR_W  instruction fetch request; address = PC
- im_ack / im_rdata  in  1 / 5+ADDR_W  fetch acknowledge; data valid when ack=1
- dm_req / dm_we  out  1 / 1  data request; 1=write
- dm_addr / dm_wdata  out  ADDR_W / DATA_W  data address, write data (=AC)
- dm_ack / dm_rdata  in  1 / DATA_W  data acknowledge; read data valid when ack=1
- end_process  out  1  sticky halt indicator
- illegal  out  1  sticky; set when halted by an undefined opcode
- ac_out  out  DATA_W  accumulator, debug visibility

## Operation
- Instruction = {opc[4:0], opd[ADDR_W-1:0]}. Register index = opd[log2(NREG)-1:0]; upper bits ignored.
- Opcodes:
  - 00 NOP
  - 01 LDI: AC←zero-ext/truncated opd
  - 02 LDM: AC←DM[opd]
  - 03 STM: DM[opd]←AC
  - 04 MVR: R←AC
  - 05 MVA: AC←R
  - 06 ADD: AC←AC+R
  - 07 SUB: AC←AC−R
  - 08 MUL: AC←low DATA_W bits of AC×R, unsigned
  - 09 INC: AC←AC+1
  - 0A CLR: AC←0
  - 0B JMP: PC←opd
  - 0C JZ: PC←opd if Z
  - 0D JNZ: PC←opd if !Z
  - 0E HLT
  - 0F–1F: illegal, halt with illegal=1
- Flags:
  - Z←(new AC==0) on every AC write.
  - C set by ADD (carry-out), SUB (borrow), INC (carry-out) and MUL (any nonzero upper product bit); other instructions hold C.
- All arithmetic is unsigned modulo 2^DATA_W. PC wraps modulo 2^ADDR_W (PC=max → 0).
- FSM states: START → FETCH → EXEC → (MEM if LDM/STM) → FETCH; HLT or illegal → HALT (absorbing until reset).
  - START: 1 cycle, no requests.
  - FETCH: im_req=1, im_addr=PC, held stable until im_ack=1. On the ack edge: IR←im_rdata, PC←PC+1.
  - EXEC: decodes IR and writes AC/R/flags/PC. For memory ops it latches dm_addr/dm_we/dm_wdata.
  - MEM: dm_req=1 with address/data/we held stable until dm_ack=1. LDM writes AC and Z on the ack edge.
  - HALT: end_process=1, no requests, registers frozen.
- A taken branch in EXEC overrides the incremented PC.

## Timing
- Reset values (asserted asynchronously, regardless of clock): state=START, PC=0, AC=0, R*=0, Z=C=0, im_req=dm_req=dm_we=0, im_addr=dm_addr=dm_wdata=0, end_process=illegal=0.
- All outputs are registered or decoded from registered state only. There are no combinational paths from ack/rdata to outputs.
- Zero-wait memory (ack in the first request cycle): non-memory instruction 2 cycles, LDM/STM 3 cycles. Each wait cycle adds 1.
- The first im_req rises on the 2nd rising edge after rst_n deasserts.
- Request is dropped in the cycle after the ack edge. Ack while req=0 is ignored.
- Reset mid-transaction abandons the request immediately; memory must tolerate a dropped req.
- Simultaneous events: the flag update and the AC write occur on the same edge. JZ/JNZ test Z as it stood before EXEC.

## Structure
- Package accum_core_pkg: OPC_W=5, opcode localparams, FSM state enum, instruction field-extract helpers.
- Sub-module accum_alu (combinational): inputs AC, R operand, opcode; outputs result, carry, zero. The core holds all state.

## Test plan
- Reset release, zero-wait memory, program LDI 5; HLT → im_req first high on edge 2; AC=5, Z=0; end_process=1 after 4 cycles; no further im_req.
- LDI 0xFFF; MVR 1; LDI 1; ADD 1 (DATA_W=12) → AC=0, Z=1, C=1.
- STM 0x020 then LDM 0x020, with dm_ack delayed 3 cycles → dm_req/addr/wdata held stable for 4 cycles; AC restored; the STM+LDM pair takes 12 cycles.
- Countdown loop: LDI 3; MVR 0; LDI 1; MVR 1; MVA 0; SUB 1; MVR 0; JNZ 4; HLT → JNZ taken exactly 2 times; halts with R0=0.
- Opcode 0x15 fetched → illegal=1, end_process=1, PC=next address; pulse rst_n low mid-FETCH → all outputs return to reset values immediately, and execution restarts from PC=0.
- PC wrap: JMP to 0xFFF holding NOP → next fetch address 0x000.

Source files
------------

// File: rtl/accum_core_pkg.sv
// Shared definitions for the accumulator core: opcode map, FSM states and
// instruction decode helpers.
package accum_core_pkg;

   localparam int OPC_W = 5;

   localparam logic [OPC_W-1:0] OP_NOP = 5'h00;
   localparam logic [OPC_W-1:0] OP_LDI = 5'h01;
   localparam logic [OPC_W-1:0] OP_LDM = 5'h02;
   localparam logic [OPC_W-1:0] OP_STM = 5'h03;
   localparam logic [OPC_W-1:0] OP_MVR = 5'h04;
   localparam logic [OPC_W-1:0] OP_MVA = 5'h05;
   localparam logic [OPC_W-1:0] OP_ADD = 5'h06;
   localparam logic [OPC_W-1:0] OP_SUB = 5'h07;
   localparam logic [OPC_W-1:0] OP_MUL = 5'h08;
   localparam logic [OPC_W-1:0] OP_INC = 5'h09;
   localparam logic [OPC_W-1:0] OP_CLR = 5'h0A;
   localparam logic [OPC_W-1:0] OP_JMP = 5'h0B;
   localparam logic [OPC_W-1:0] OP_JZ  = 5'h0C;
   localparam logic [OPC_W-1:0] OP_JNZ = 5'h0D;
   localparam logic [OPC_W-1:0] OP_HLT = 5'h0E;

   typedef enum logic [2:0] {
      ST_START = 3'd0,
      ST_FETCH = 3'd1,
      ST_EXEC  = 3'd2,
      ST_MEM   = 3'd3,
      ST_HALT  = 3'd4
   } state_e;

   // Field extraction works on a zero-extended 64-bit copy so the helpers stay width-generic.
   function automatic logic [OPC_W-1:0] instr_opc(input logic [63:0] instr, input int addr_w);
      logic [63:0] sh;
      sh = instr >> addr_w;
      return sh[OPC_W-1:0];
   endfunction

   function automatic logic [63:0] instr_opd(input logic [63:0] instr, input int addr_w);
      logic [63:0] mask;
      mask = ~({64{1'b1}} << addr_w);
      return instr & mask;
   endfunction

   function automatic logic is_legal(input logic [OPC_W-1:0] opc);
      return (opc <= OP_HLT);
   endfunction

   function automatic logic is_mem_op(input logic [OPC_W-1:0] opc);
      return (opc == OP_LDM) || (opc == OP_STM);
   endfunction

endpackage

// File: rtl/accum_alu.sv
// Combinational ALU for the accumulator core; all state lives in the core.
module accum_alu
   import accum_core_pkg::*;
#(
   parameter int DATA_W = 12
)
(
   input  logic [DATA_W-1:0] ac_i,
   input  logic [DATA_W-1:0] opnd_i,
   input  logic [OPC_W-1:0]  opc_i,
   output logic [DATA_W-1:0] result_o,
   output logic              carry_o,
   output logic              zero_o
);

   logic [DATA_W:0]     sum_s;
   logic [DATA_W:0]     diff_s;
   logic [DATA_W:0]     inc_s;
   logic [2*DATA_W-1:0] prod_s;

   // Borrow of SUB is the wrapped MSB of the widened difference.
   always_comb begin
      sum_s    = {1'b0, ac_i} + {1'b0, opnd_i};
      diff_s   = {1'b0, ac_i} - {1'b0, opnd_i};
      inc_s    = {1'b0, ac_i} + {{DATA_W{1'b0}}, 1'b1};
      prod_s   = {{DATA_W{1'b0}}, ac_i} * {{DATA_W{1'b0}}, opnd_i};
      result_o = '0;
      carry_o  = 1'b0;
      case (opc_i)
         OP_LDI, OP_MVA: result_o = opnd_i;
         OP_ADD: begin
            result_o = sum_s[DATA_W-1:0];
            carry_o  = sum_s[DATA_W];
         end
         OP_SUB: begin
            result_o = diff_s[DATA_W-1:0];
            carry_o  = diff_s[DATA_W];
         end
         OP_MUL: begin
            result_o = prod_s[DATA_W-1:0];
            carry_o  = |prod_s[2*DATA_W-1:DATA_W];
         end
         OP_INC: begin
            result_o = inc_s[DATA_W-1:0];
            carry_o  = inc_s[DATA_W];
         end
         default: result_o = '0;
      endcase
      zero_o = (result_o == '0);
   end

endmodule

// File: rtl/accum_core.sv
// Multi-cycle accumulator core with handshaked instruction/data memory,
// zero/carry flags, conditional branches and sticky halt/illegal trapping.
module accum_core
   import accum_core_pkg::*;
#(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 12,
   parameter int NREG   = 4
)
(
   input  logic                    clk,
   input  logic                    rst_n,
   output logic                    im_req,
   output logic [ADDR_W-1:0]       im_addr,
   input  logic                    im_ack,
   input  logic [OPC_W+ADDR_W-1:0] im_rdata,
   output logic                    dm_req,
   output logic                    dm_we,
   output logic [ADDR_W-1:0]       dm_addr,
   output logic [DATA_W-1:0]       dm_wdata,
   input  logic                    dm_ack,
   input  logic [DATA_W-1:0]       dm_rdata,
   output logic                    end_process,
   output logic                    illegal,
   output logic [DATA_W-1:0]       ac_out
);

   localparam int IW = OPC_W + ADDR_W;
   localparam int RW = $clog2(NREG);

   state_e            state_q, state_d;
   logic              arm_q;
   logic [ADDR_W-1:0] pc_q, pc_d, dm_addr_q, dm_addr_d;
   logic [DATA_W-1:0] ac_q, ac_d, dm_wdata_q, dm_wdata_d;
   logic [IW-1:0]     ir_q, ir_d;
   logic              z_q, z_d, c_q, c_d, dm_we_q, dm_we_d, illegal_q, illegal_d;
   logic [DATA_W-1:0] regs_q [NREG];

   logic              reg_we_s;
   logic [RW-1:0]     reg_idx_s;
   logic [OPC_W-1:0]  opc_s;
   logic [ADDR_W-1:0] opd_s;
   logic [DATA_W-1:0] opnd_s, alu_res_s;
   logic              alu_c_s, alu_z_s;

   assign opc_s     = instr_opc(64'(ir_q), ADDR_W);
   assign opd_s     = ADDR_W'(instr_opd(64'(ir_q), ADDR_W));
   assign reg_idx_s = opd_s[RW-1:0];
   assign opnd_s    = (opc_s == OP_LDI) ? DATA_W'(opd_s) : regs_q[reg_idx_s];

   accum_alu #(.DATA_W(DATA_W)) u_alu (
      .ac_i     (ac_q),
      .opnd_i   (opnd_s),
      .opc_i    (opc_s),
      .result_o (alu_res_s),
      .carry_o  (alu_c_s),
      .zero_o   (alu_z_s)
   );

   // State register; arm_q holds START through the first edge after reset release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_START;
         arm_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         arm_q   <= 1'b1;
      end
   end

   // Next-state decode.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_START: state_d = arm_q ? ST_FETCH : ST_START;
         ST_FETCH: state_d = im_ack ? ST_EXEC : ST_FETCH;
         ST_EXEC: begin
            if ((opc_s == OP_HLT) || !is_legal(opc_s)) begin
               state_d = ST_HALT;
            end else if (is_mem_op(opc_s)) begin
               state_d = ST_MEM;
            end else begin
               state_d = ST_FETCH;
            end
         end
         ST_MEM:  state_d = dm_ack ? ST_FETCH : ST_MEM;
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_START;
      endcase
   end

   // Datapath next values per state.
   always_comb begin
      pc_d       = pc_q;
      ac_d       = ac_q;
      ir_d       = ir_q;
      z_d        = z_q;
      c_d        = c_q;
      dm_addr_d  = dm_addr_q;
      dm_wdata_d = dm_wdata_q;
      dm_we_d    = dm_we_q;
      illegal_d  = illegal_q;
      reg_we_s   = 1'b0;
      case (state_q)
         ST_FETCH: begin
            if (im_ack) begin
               ir_d = im_rdata;
               pc_d = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};
            end else begin
               ir_d = ir_q;
            end
         end
         ST_EXEC: begin
            case (opc_s)
               OP_LDI, OP_MVA, OP_CLR: begin
                  ac_d = alu_res_s;
                  z_d  = alu_z_s;
               end
               OP_ADD, OP_SUB, OP_MUL, OP_INC: begin
                  ac_d = alu_res_s;
                  z_d  = alu_z_s;
                  c_d  = alu_c_s;
               end
               OP_LDM, OP_STM: begin
                  dm_addr_d  = opd_s;
                  dm_wdata_d = ac_q;
                  dm_we_d    = (opc_s == OP_STM);
               end
               OP_MVR:  reg_we_s = 1'b1;
               OP_JMP:  pc_d = opd_s;
               OP_JZ:   pc_d = z_q ? opd_s : pc_q;
               OP_JNZ:  pc_d = z_q ? pc_q : opd_s;
               default: illegal_d = !is_legal(opc_s);
            endcase
         end
         ST_MEM: begin
            if (dm_ack) begin
               if (!dm_we_q) begin
                  ac_d = dm_rdata;
                  z_d  = (dm_rdata == '0);
               end else begin
                  ac_d = ac_q;
               end
               dm_we_d = 1'b0;
            end else begin
               dm_we_d = dm_we_q;
            end
         end
         default: pc_d = pc_q;
      endcase
   end

   // Datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q       <= '0;
         ac_q       <= '0;
         ir_q       <= '0;
         z_q        <= 1'b0;
         c_q        <= 1'b0;
         dm_addr_q  <= '0;
         dm_wdata_q <= '0;
         dm_we_q    <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         ac_q       <= ac_d;
         ir_q       <= ir_d;
         z_q        <= z_d;
         c_q        <= c_d;
         dm_addr_q  <= dm_addr_d;
         dm_wdata_q <= dm_wdata_d;
         dm_we_q    <= dm_we_d;
         illegal_q  <= illegal_d;
      end
   end

   // General register file, written only by MVR.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      end else if (reg_we_s) begin
         regs_q[reg_idx_s] <= ac_q;
      end
   end

   assign im_req      = (state_q == ST_FETCH);
   assign im_addr     = pc_q;
   assign dm_req      = (state_q == ST_MEM);
   assign dm_we       = dm_we_q;
   assign dm_addr     = dm_addr_q;
   assign dm_wdata    = dm_wdata_q;
   assign end_process = (state_q == ST_HALT);
   assign illegal     = illegal_q;
   assign ac_out      = ac_q;

endmodule

// File: tb/tb_accum_core.sv
// Directed bench for accum_core with behavioural instruction/data memories
// that insert a configurable number of wait states.
module tb_accum_core;

   localparam logic [4:0] NOP = 5'h00, LDI = 5'h01, LDM = 5'h02, STM = 5'h03,
                          MVR = 5'h04, MVA = 5'h05, ADD = 5'h06, SUB = 5'h07,
                          MUL = 5'h08, CLR = 5'h0A, JMP = 5'h0B, JNZ = 5'h0D,
                          HLT = 5'h0E;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        im_req, im_ack = 1'b0;
   logic [11:0] im_addr;
   logic [16:0] im_rdata = '0;
   logic        dm_req, dm_we, dm_ack = 1'b0;
   logic [11:0] dm_addr, dm_wdata, dm_rdata = '0;
   logic        end_process, illegal;
   logic [11:0] ac_out;

   logic [16:0] imem [4096];
   logic [11:0] dmem [4096];
   int im_delay = 0, dm_delay = 0, im_cnt = 0, dm_cnt = 0;
   logic [11:0] fa [64];
   int n_fa = 0, dm_cyc = 0;
   logic dm_unstable = 1'b0;
   logic [11:0] ref_a, ref_w;
   logic ref_we;
   int n_chk = 0, n_bad = 0;

   accum_core #(.DATA_W(12), .ADDR_W(12), .NREG(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .im_req(im_req), .im_addr(im_addr), .im_ack(im_ack), .im_rdata(im_rdata),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_ack(dm_ack), .dm_rdata(dm_rdata),
      .end_process(end_process), .illegal(illegal), .ac_out(ac_out)
   );

   always #5 clk = ~clk;

   // Memory models respond on the falling edge so acks are stable at the next rising edge.
   always @(negedge clk) begin
      if (im_req) begin
         im_rdata = imem[im_addr];
         if (im_cnt == im_delay) begin
            im_ack = 1'b1;
            im_cnt = 0;
            if (n_fa < 64) begin
               fa[n_fa] = im_addr;
               n_fa++;
            end
         end else begin
            im_ack = 1'b0;
            im_cnt++;
         end
      end else begin
         im_ack = 1'b0;
         im_cnt = 0;
      end
      if (dm_req) begin
         dm_cyc++;
         if (dm_cnt == 0) begin
            ref_a = dm_addr; ref_w = dm_wdata; ref_we = dm_we;
         end else if (dm_addr != ref_a || dm_wdata != ref_w || dm_we != ref_we) begin
            dm_unstable = 1'b1;
         end
         dm_rdata = dmem[dm_addr];
         if (dm_cnt == dm_delay) begin
            dm_ack = 1'b1;
            dm_cnt = 0;
            if (dm_we) dmem[dm_addr] = dm_wdata;
         end else begin
            dm_ack = 1'b0;
            dm_cnt++;
         end
      end else begin
         dm_ack = 1'b0;
         dm_cnt = 0;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [16:0] ins(input logic [4:0] op, input logic [11:0] d);
      return {op, d};
   endfunction

   task automatic clear_imem();
      for (int i = 0; i < 4096; i++) imem[i] = ins(HLT, 12'h000);
   endtask

   task automatic reset_core();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      n_fa = 0; dm_cyc = 0; dm_unstable = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic run_to_halt(input string tag, input int maxc);
      int cyc;
      cyc = 0;
      while (!end_process && cyc < maxc) begin
         @(posedge clk); #1;
         cyc++;
      end
      check_eq(tag, {31'd0, end_process}, 32'd1);
   endtask

   initial begin
      int t_end, t1, t2, t3, t4, n4;
      logic req_after;
      logic [11:0] wrap_exp [6];

      for (int i = 0; i < 4096; i++) dmem[i] = 12'h000;

      // reset values and first-fetch / halt timing
      clear_imem();
      imem[0] = ins(LDI, 12'h005);
      imem[1] = ins(HLT, 12'h000);
      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_im_req", {31'd0, im_req}, 32'd0);
      check_eq("rst_im_addr", {20'd0, im_addr}, 32'd0);
      check_eq("rst_dm_req", {31'd0, dm_req}, 32'd0);
      check_eq("rst_ac", {20'd0, ac_out}, 32'd0);
      check_eq("rst_end", {31'd0, end_process}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      t_end = 0; req_after = 1'b0;
      for (int e = 1; e <= 14; e++) begin
         @(posedge clk); #1;
         if (e == 1) check_eq("req_edge1", {31'd0, im_req}, 32'd0);
         if (e == 2) check_eq("req_edge2", {31'd0, im_req}, 32'd1);
         if (end_process && t_end == 0) t_end = e;
         if (end_process && im_req) req_after = 1'b1;
      end
      check_eq("halt_edge", t_end, 32'd6);
      check_eq("ldi_ac", {20'd0, ac_out}, 32'h005);
      check_eq("ldi_z", {31'd0, dut.z_q}, 32'd0);
      check_eq("no_req_halt", {31'd0, req_after}, 32'd0);
      check_eq("fetch_count", n_fa, 32'd2);

      // ADD carry-out wraps AC to zero
      clear_imem();
      imem[0] = ins(LDI, 12'hFFF); imem[1] = ins(MVR, 12'h001);
      imem[2] = ins(LDI, 12'h001); imem[3] = ins(ADD, 12'h001);
      reset_core();
      run_to_halt("add_halt", 40);
      check_eq("add_ac", {20'd0, ac_out}, 32'h000);
      check_eq("add_z", {31'd0, dut.z_q}, 32'd1);
      check_eq("add_c", {31'd0, dut.c_q}, 32'd1);

      // SUB borrow, register index upper bits ignored
      clear_imem();
      imem[0] = ins(LDI, 12'h002); imem[1] = ins(MVR, 12'h003);
      imem[2] = ins(LDI, 12'h001); imem[3] = ins(SUB, 12'h103);
      reset_core();
      run_to_halt("sub_halt", 40);
      check_eq("sub_ac", {20'd0, ac_out}, 32'hFFF);
      check_eq("sub_z", {31'd0, dut.z_q}, 32'd0);
      check_eq("sub_c", {31'd0, dut.c_q}, 32'd1);

      // MUL overflow sets C; LDI afterwards holds C
      clear_imem();
      imem[0] = ins(LDI, 12'h003); imem[1] = ins(MVR, 12'h002);
      imem[2] = ins(LDI, 12'h801); imem[3] = ins(MUL, 12'h002);
      imem[4] = ins(MVR, 12'h001); imem[5] = ins(LDI, 12'h000);
      reset_core();
      run_to_halt("mul_halt", 40);
      check_eq("mul_r1", {20'd0, dut.regs_q[1]}, 32'h803);
      check_eq("mul_z", {31'd0, dut.z_q}, 32'd1);
      check_eq("mul_c_held", {31'd0, dut.c_q}, 32'd1);

      // STM/LDM with three data wait states
      clear_imem();
      imem[0] = ins(LDI, 12'h5A5); imem[1] = ins(STM, 12'h020);
      imem[2] = ins(CLR, 12'h000); imem[3] = ins(LDM, 12'h020);
      dm_delay = 3;
      reset_core();
      t1 = -100; t2 = -100; t3 = -100; t4 = -100;
      for (int e = 1; e <= 80 && !end_process; e++) begin
         @(posedge clk); #1;
         if (im_req && im_addr == 12'h001 && t1 < 0) t1 = e;
         if (im_req && im_addr == 12'h002 && t2 < 0) t2 = e;
         if (im_req && im_addr == 12'h003 && t3 < 0) t3 = e;
         if (im_req && im_addr == 12'h004 && t4 < 0) t4 = e;
      end
      check_eq("mem_halt", {31'd0, end_process}, 32'd1);
      check_eq("stm_cycles", t2 - t1, 32'd6);
      check_eq("clr_cycles", t3 - t2, 32'd2);
      check_eq("ldm_cycles", t4 - t3, 32'd6);
      check_eq("dm_req_cycles", dm_cyc, 32'd8);
      check_eq("dm_stable", {31'd0, dm_unstable}, 32'd0);
      check_eq("dmem_20", {20'd0, dmem[12'h020]}, 32'h5A5);
      check_eq("ldm_ac", {20'd0, ac_out}, 32'h5A5);
      dm_delay = 0;

      // countdown loop
      clear_imem();
      imem[0] = ins(LDI, 12'h003); imem[1] = ins(MVR, 12'h000);
      imem[2] = ins(LDI, 12'h001); imem[3] = ins(MVR, 12'h001);
      imem[4] = ins(MVA, 12'h000); imem[5] = ins(SUB, 12'h001);
      imem[6] = ins(MVR, 12'h000); imem[7] = ins(JNZ, 12'h004);
      imem[8] = ins(HLT, 12'h000);
      reset_core();
      run_to_halt("loop_halt", 200);
      n4 = 0;
      for (int i = 0; i < n_fa; i++) if (fa[i] == 12'h004) n4++;
      check_eq("jnz_taken", n4 - 1, 32'd2);
      check_eq("loop_r0", {20'd0, dut.regs_q[0]}, 32'h000);
      check_eq("loop_z", {31'd0, dut.z_q}, 32'd1);

      // PC wrap: JNZ taken, JMP to top address, wrap to 0, JNZ falls through
      clear_imem();
      imem[0] = ins(JNZ, 12'h002); imem[1] = ins(HLT, 12'h000);
      imem[2] = ins(LDI, 12'h000); imem[3] = ins(JMP, 12'hFFF);
      imem[12'hFFF] = ins(NOP, 12'h000);
      wrap_exp[0] = 12'h000; wrap_exp[1] = 12'h002; wrap_exp[2] = 12'h003;
      wrap_exp[3] = 12'hFFF; wrap_exp[4] = 12'h000; wrap_exp[5] = 12'h001;
      reset_core();
      run_to_halt("wrap_halt", 60);
      check_eq("wrap_nfetch", n_fa, 32'd6);
      for (int i = 0; i < 6; i++) check_eq($sformatf("wrap_fa%0d", i), {20'd0, fa[i]}, {20'd0, wrap_exp[i]});

      // illegal opcode trap
      clear_imem();
      imem[0] = ins(LDI, 12'h007); imem[1] = ins(5'h15, 12'h000);
      imem[2] = ins(NOP, 12'h000);
      reset_core();
      run_to_halt("ill_halt", 40);
      check_eq("ill_flag", {31'd0, illegal}, 32'd1);
      check_eq("ill_pc", {20'd0, im_addr}, 32'h002);
      check_eq("ill_ac", {20'd0, ac_out}, 32'h007);
      #3 rst_n = 1'b0;
      #1;
      check_eq("ill_rst_flag", {31'd0, illegal}, 32'd0);
      check_eq("ill_rst_end", {31'd0, end_process}, 32'd0);

      // reset pulse in the middle of a stalled fetch
      clear_imem();
      imem[0] = ins(LDI, 12'h009);
      im_delay = 3;
      reset_core();
      for (int e = 0; e < 40 && !(im_req && im_addr == 12'h001); e++) begin
         @(posedge clk); #1;
      end
      @(posedge clk); #1;
      check_eq("mid_fetch", {31'd0, im_req}, 32'd1);
      check_eq("mid_ac", {20'd0, ac_out}, 32'h009);
      rst_n = 1'b0;
      #1;
      check_eq("pulse_req", {31'd0, im_req}, 32'd0);
      check_eq("pulse_addr", {20'd0, im_addr}, 32'h000);
      check_eq("pulse_ac", {20'd0, ac_out}, 32'h000);
      n_fa = 0;
      @(negedge clk);
      rst_n = 1'b1;
      run_to_halt("restart_halt", 60);
      check_eq("restart_fa0", {20'd0, fa[0]}, 32'h000);
      check_eq("restart_ac", {20'd0, ac_out}, 32'h009);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
